// File: rtl/axi_dac_jesd204_up_arb_pkg.sv
// Shared types and constants for the JESD204 DAC up_* bus arbiter.
// Holds FSM state encodings, request-type encoding and the round-robin pick.
package axi_dac_jesd204_up_arb_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [DATA_W-1:0] DEFAULT_TIMEOUT_RDATA = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_WRITE = 1'b0,
        REQ_READ  = 1'b1
    } req_type_t;

    // With both requesters pending, the one not granted last wins.
    function automatic logic rr_pick(input logic pend0, input logic pend1,
                                     input logic last_grant);
        if (pend0 && pend1) begin
            return ~last_grant;
        end
        return pend1;
    endfunction

endpackage

// File: rtl/axi_dac_jesd204_up_req_slot.sv
// One pending request slot: valid bit plus latched payload (address, and data
// for write slots). A request into an occupied slot is flagged as dropped.
module axi_dac_jesd204_up_req_slot #(
    parameter int PAYLOAD_W = 14
) (
    input  logic                 up_clk,
    input  logic                 up_rstn,
    input  logic                 req,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic                 clr,
    output logic                 valid,
    output logic [PAYLOAD_W-1:0] payload,
    output logic                 drop
);

    // A slot being cleared this cycle counts as free, so a back-to-back
    // request issued in the ack cycle is accepted rather than dropped.
    assign drop = req && valid && !clr;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (req && (!valid || clr)) begin
            valid   <= 1'b1;
            payload <= payload_in;
        end else if (clr) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_dac_jesd204_up_arb.sv
// Two-requester arbiter for the JESD204 DAC up_* register bus: serializes
// single-beat reads/writes downstream, routes acks back, aborts on timeout.
module axi_dac_jesd204_up_arb
    import axi_dac_jesd204_up_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
    input  logic        up_clk,
    input  logic        up_rstn,

    input  logic        s0_up_wreq,
    input  logic [13:0] s0_up_waddr,
    input  logic [31:0] s0_up_wdata,
    output logic        s0_up_wack,
    input  logic        s0_up_rreq,
    input  logic [13:0] s0_up_raddr,
    output logic [31:0] s0_up_rdata,
    output logic        s0_up_rack,

    input  logic        s1_up_wreq,
    input  logic [13:0] s1_up_waddr,
    input  logic [31:0] s1_up_wdata,
    output logic        s1_up_wack,
    input  logic        s1_up_rreq,
    input  logic [13:0] s1_up_raddr,
    output logic [31:0] s1_up_rdata,
    output logic        s1_up_rack,

    output logic        m_up_wreq,
    output logic [13:0] m_up_waddr,
    output logic [31:0] m_up_wdata,
    input  logic        m_up_wack,
    output logic        m_up_rreq,
    output logic [13:0] m_up_raddr,
    input  logic [31:0] m_up_rdata,
    input  logic        m_up_rack,

    output logic [1:0]  up_drop,
    output logic        up_timeout,
    input  logic        up_timeout_clr
);

    localparam int WPL_W = ADDR_W + DATA_W;
    // The counter is compared one short of TIMEOUT_CYCLES-1 so that the
    // registered abort ack lands exactly TIMEOUT_CYCLES after the issue cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [1:0]        w_req, r_req, w_valid, r_valid, w_drop, r_drop, w_clr, r_clr;
    logic [WPL_W-1:0]  w_in [2];
    logic [WPL_W-1:0]  w_pl [2];
    logic [ADDR_W-1:0] r_in [2];
    logic [ADDR_W-1:0] r_pl [2];

    arb_state_t        state;
    req_type_t         grant_type;
    logic              grant_id;
    logic              rr_last;
    logic [CNT_W-1:0]  wait_cnt;

    logic [1:0]        pend;
    logic              sel_id, sel_write, ack_hit, to_hit, done;

    assign w_req   = {s1_up_wreq, s0_up_wreq};
    assign r_req   = {s1_up_rreq, s0_up_rreq};
    assign w_in[0] = {s0_up_waddr, s0_up_wdata};
    assign w_in[1] = {s1_up_waddr, s1_up_wdata};
    assign r_in[0] = s0_up_raddr;
    assign r_in[1] = s1_up_raddr;

    for (genvar i = 0; i < 2; i++) begin : g_slot
        axi_dac_jesd204_up_req_slot #(.PAYLOAD_W(WPL_W)) u_wslot (
            .up_clk     (up_clk),
            .up_rstn    (up_rstn),
            .req        (w_req[i]),
            .payload_in (w_in[i]),
            .clr        (w_clr[i]),
            .valid      (w_valid[i]),
            .payload    (w_pl[i]),
            .drop       (w_drop[i])
        );

        axi_dac_jesd204_up_req_slot #(.PAYLOAD_W(ADDR_W)) u_rslot (
            .up_clk     (up_clk),
            .up_rstn    (up_rstn),
            .req        (r_req[i]),
            .payload_in (r_in[i]),
            .clr        (r_clr[i]),
            .valid      (r_valid[i]),
            .payload    (r_pl[i]),
            .drop       (r_drop[i])
        );
    end

    // Only the ack of the issued type is honoured; an ack beats a same-cycle timeout.
    always_comb begin
        pend      = w_valid | r_valid;
        sel_id    = rr_pick(pend[0], pend[1], rr_last);
        sel_write = w_valid[sel_id];
        ack_hit   = 1'b0;
        if (state == ST_WAIT) begin
            ack_hit = (grant_type == REQ_WRITE) ? m_up_wack : m_up_rack;
        end
        to_hit = (state == ST_WAIT) && !ack_hit && (wait_cnt == TO_LAST);
        done   = ack_hit || to_hit;
        w_clr  = '0;
        r_clr  = '0;
        if (done) begin
            if (grant_type == REQ_WRITE) begin
                w_clr[grant_id] = 1'b1;
            end else begin
                r_clr[grant_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state       <= ST_IDLE;
            grant_type  <= REQ_WRITE;
            grant_id    <= 1'b0;
            rr_last     <= 1'b1;
            wait_cnt    <= '0;
            m_up_wreq   <= 1'b0;
            m_up_rreq   <= 1'b0;
            m_up_waddr  <= '0;
            m_up_wdata  <= '0;
            m_up_raddr  <= '0;
            s0_up_wack  <= 1'b0;
            s0_up_rack  <= 1'b0;
            s0_up_rdata <= '0;
            s1_up_wack  <= 1'b0;
            s1_up_rack  <= 1'b0;
            s1_up_rdata <= '0;
            up_drop     <= '0;
            up_timeout  <= 1'b0;
        end else begin
            m_up_wreq   <= 1'b0;
            m_up_rreq   <= 1'b0;
            s0_up_wack  <= 1'b0;
            s0_up_rack  <= 1'b0;
            s0_up_rdata <= '0;
            s1_up_wack  <= 1'b0;
            s1_up_rack  <= 1'b0;
            s1_up_rdata <= '0;
            up_drop     <= w_drop | r_drop;

            case (state)
                ST_IDLE: begin
                    if (pend != 2'b00) begin
                        grant_id <= sel_id;
                        rr_last  <= sel_id;
                        state    <= ST_ISSUE;
                        if (sel_write) begin
                            grant_type <= REQ_WRITE;
                            m_up_wreq  <= 1'b1;
                            m_up_waddr <= w_pl[sel_id][WPL_W-1:DATA_W];
                            m_up_wdata <= w_pl[sel_id][DATA_W-1:0];
                        end else begin
                            grant_type <= REQ_READ;
                            m_up_rreq  <= 1'b1;
                            m_up_raddr <= r_pl[sel_id];
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                        if (grant_type == REQ_WRITE) begin
                            s0_up_wack <= !grant_id;
                            s1_up_wack <= grant_id;
                        end else if (!grant_id) begin
                            s0_up_rack  <= 1'b1;
                            s0_up_rdata <= ack_hit ? m_up_rdata : TIMEOUT_RDATA;
                        end else begin
                            s1_up_rack  <= 1'b1;
                            s1_up_rdata <= ack_hit ? m_up_rdata : TIMEOUT_RDATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (to_hit) begin
                up_timeout <= 1'b1;
            end else if (up_timeout_clr) begin
                up_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_dac_jesd204_up_arb.sv
// Self-checking bench for axi_dac_jesd204_up_arb: expected downstream issues
// and upstream acks are queued with stimulus and matched against a monitor.
module tb_axi_dac_jesd204_up_arb;

    localparam int TO_CYC = 8;

    logic        up_clk = 1'b0;
    logic        up_rstn;
    logic        s0_up_wreq, s0_up_rreq, s1_up_wreq, s1_up_rreq;
    logic [13:0] s0_up_waddr, s0_up_raddr, s1_up_waddr, s1_up_raddr;
    logic [31:0] s0_up_wdata, s1_up_wdata;
    logic        s0_up_wack, s0_up_rack, s1_up_wack, s1_up_rack;
    logic [31:0] s0_up_rdata, s1_up_rdata;
    logic        m_up_wreq, m_up_rreq, m_up_wack, m_up_rack;
    logic [13:0] m_up_waddr, m_up_raddr;
    logic [31:0] m_up_wdata, m_up_rdata;
    logic [1:0]  up_drop;
    logic        up_timeout, up_timeout_clr;

    axi_dac_jesd204_up_arb #(.TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_RDATA(32'hDEAD_DEAD)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .s0_up_wreq(s0_up_wreq), .s0_up_waddr(s0_up_waddr), .s0_up_wdata(s0_up_wdata),
        .s0_up_wack(s0_up_wack), .s0_up_rreq(s0_up_rreq), .s0_up_raddr(s0_up_raddr),
        .s0_up_rdata(s0_up_rdata), .s0_up_rack(s0_up_rack),
        .s1_up_wreq(s1_up_wreq), .s1_up_waddr(s1_up_waddr), .s1_up_wdata(s1_up_wdata),
        .s1_up_wack(s1_up_wack), .s1_up_rreq(s1_up_rreq), .s1_up_raddr(s1_up_raddr),
        .s1_up_rdata(s1_up_rdata), .s1_up_rack(s1_up_rack),
        .m_up_wreq(m_up_wreq), .m_up_waddr(m_up_waddr), .m_up_wdata(m_up_wdata),
        .m_up_wack(m_up_wack), .m_up_rreq(m_up_rreq), .m_up_raddr(m_up_raddr),
        .m_up_rdata(m_up_rdata), .m_up_rack(m_up_rack),
        .up_drop(up_drop), .up_timeout(up_timeout), .up_timeout_clr(up_timeout_clr)
    );

    always #5 up_clk = ~up_clk;

    int cyc = 0;
    always @(posedge up_clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit w; logic [13:0] addr; logic [31:0] data; } issue_t;
    typedef struct { int cyc; int id; bit w; logic [31:0] rdata; } ack_t;

    issue_t     exp_issue[$], obs_issue[$];
    ack_t       exp_ack[$], obs_ack[$];
    int         obs_drop_cyc[$];
    logic [1:0] obs_drop_bits[$];

    int checks = 0;
    int errors = 0;
    int rdata_leak = 0;
    bit resp_en = 1'b1;
    int resp_delay = 2;

    function automatic issue_t mk_issue(int c, bit w, logic [13:0] a, logic [31:0] d);
        issue_t t;
        t.cyc = c; t.w = w; t.addr = a; t.data = d;
        return t;
    endfunction

    function automatic ack_t mk_ack(int c, int id, bit w, logic [31:0] rd);
        ack_t t;
        t.cyc = c; t.id = id; t.w = w; t.rdata = rd;
        return t;
    endfunction

    // Downstream register file contents as seen by reads.
    function automatic logic [31:0] resp_data(logic [13:0] a);
        case (a)
            14'h0100: return 32'hAAAA_0000;
            14'h0200: return 32'h5555_FFFF;
            default:  return {18'h0, a} ^ 32'h1357_9BDF;
        endcase
    endfunction

    always @(negedge up_clk) begin
        if (m_up_wreq) obs_issue.push_back(mk_issue(cyc, 1'b1, m_up_waddr, m_up_wdata));
        if (m_up_rreq) obs_issue.push_back(mk_issue(cyc, 1'b0, m_up_raddr, 32'h0));
        if (s0_up_wack) obs_ack.push_back(mk_ack(cyc, 0, 1'b1, 32'h0));
        if (s0_up_rack) obs_ack.push_back(mk_ack(cyc, 0, 1'b0, s0_up_rdata));
        if (s1_up_wack) obs_ack.push_back(mk_ack(cyc, 1, 1'b1, 32'h0));
        if (s1_up_rack) obs_ack.push_back(mk_ack(cyc, 1, 1'b0, s1_up_rdata));
        if (up_drop != 2'b00) begin
            obs_drop_cyc.push_back(cyc);
            obs_drop_bits.push_back(up_drop);
        end
        if ((!s0_up_rack && s0_up_rdata != 32'h0) || (!s1_up_rack && s1_up_rdata != 32'h0))
            rdata_leak++;
    end

    initial begin : responder
        logic        is_w;
        logic [31:0] rd;
        m_up_wack  = 1'b0;
        m_up_rack  = 1'b0;
        m_up_rdata = 32'h0;
        forever begin
            @(negedge up_clk);
            if (resp_en && up_rstn && (m_up_wreq || m_up_rreq)) begin
                is_w = m_up_wreq;
                rd   = resp_data(m_up_raddr);
                repeat (resp_delay) @(posedge up_clk);
                #1;
                if (is_w) m_up_wack = 1'b1;
                else begin
                    m_up_rack  = 1'b1;
                    m_up_rdata = rd;
                end
                @(posedge up_clk);
                #1;
                m_up_wack  = 1'b0;
                m_up_rack  = 1'b0;
                m_up_rdata = 32'h0;
            end
        end
    end

    task automatic step();
        @(posedge up_clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_issue.delete(); obs_issue.delete();
        exp_ack.delete();   obs_ack.delete();
        obs_drop_cyc.delete(); obs_drop_bits.delete();
    endtask

    task automatic wait_for(int n_issue, int n_ack, int budget, output bit ok);
        int k = 0;
        while ((obs_issue.size() < n_issue || obs_ack.size() < n_ack) && k < budget) begin
            step();
            k++;
        end
        ok = (obs_issue.size() >= n_issue) && (obs_ack.size() >= n_ack);
        repeat (3) step();
    endtask

    task automatic test_reset();
        checks++;
        if ({m_up_wreq, m_up_rreq, m_up_waddr, m_up_raddr, m_up_wdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_m_side got %h want 0", {m_up_wreq, m_up_rreq, m_up_waddr, m_up_raddr, m_up_wdata});
        end
        checks++;
        if ({s0_up_wack, s0_up_rack, s0_up_rdata, s1_up_wack, s1_up_rack, s1_up_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_s_side got %h want 0", {s0_up_wack, s0_up_rack, s0_up_rdata, s1_up_wack, s1_up_rack, s1_up_rdata});
        end
        checks++;
        if ({up_drop, up_timeout} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 000", {up_drop, up_timeout});
        end
    endtask

    task automatic test_fairness();
        bit ok; int c; issue_t ei, oi; ack_t ea, oa;
        clear_queues();
        resp_en = 1'b1; resp_delay = 2;
        step(); c = cyc;
        s0_up_rreq = 1'b1; s0_up_raddr = 14'h0100;
        s1_up_rreq = 1'b1; s1_up_raddr = 14'h0200;
        exp_issue.push_back(mk_issue(c + 2, 1'b0, 14'h0100, 0));
        exp_ack.push_back(mk_ack(c + 5, 0, 1'b0, 32'hAAAA_0000));
        exp_issue.push_back(mk_issue(c + 6, 1'b0, 14'h0200, 0));
        exp_ack.push_back(mk_ack(c + 9, 1, 1'b0, 32'h5555_FFFF));
        step(); s0_up_rreq = 1'b0; s1_up_rreq = 1'b0;
        wait_for(2, 2, 40, ok);
        step(); c = cyc;
        s0_up_rreq = 1'b1; s0_up_raddr = 14'h0300;
        exp_issue.push_back(mk_issue(c + 2, 1'b0, 14'h0300, 0));
        exp_ack.push_back(mk_ack(c + 5, 0, 1'b0, resp_data(14'h0300)));
        step(); s0_up_rreq = 1'b0;
        wait_for(3, 3, 40, ok);
        step(); c = cyc;
        s0_up_rreq = 1'b1; s0_up_raddr = 14'h0100;
        s1_up_rreq = 1'b1; s1_up_raddr = 14'h0200;
        exp_issue.push_back(mk_issue(c + 2, 1'b0, 14'h0200, 0));
        exp_ack.push_back(mk_ack(c + 5, 1, 1'b0, 32'h5555_FFFF));
        exp_issue.push_back(mk_issue(c + 6, 1'b0, 14'h0100, 0));
        exp_ack.push_back(mk_ack(c + 9, 0, 1'b0, 32'hAAAA_0000));
        step(); s0_up_rreq = 1'b0; s1_up_rreq = 1'b0;
        wait_for(5, 5, 40, ok);
        checks++;
        if (obs_issue.size() != exp_issue.size() || obs_ack.size() != exp_ack.size()) begin
            errors++;
            $display("[TB] FAIL fair_count got %0d/%0d want %0d/%0d", obs_issue.size(), obs_ack.size(), exp_issue.size(), exp_ack.size());
        end
        while (exp_issue.size() > 0 && obs_issue.size() > 0) begin
            ei = exp_issue.pop_front(); oi = obs_issue.pop_front();
            checks++;
            if (oi.cyc !== ei.cyc || oi.w !== ei.w || oi.addr !== ei.addr) begin
                errors++;
                $display("[TB] FAIL fair_issue got cyc=%0d w=%0b addr=%h want cyc=%0d w=%0b addr=%h", oi.cyc, oi.w, oi.addr, ei.cyc, ei.w, ei.addr);
            end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front();
            checks++;
            if (oa.cyc !== ea.cyc || oa.id !== ea.id || oa.w !== ea.w || oa.rdata !== ea.rdata) begin
                errors++;
                $display("[TB] FAIL fair_ack got cyc=%0d id=%0d w=%0b rd=%h want cyc=%0d id=%0d w=%0b rd=%h", oa.cyc, oa.id, oa.w, oa.rdata, ea.cyc, ea.id, ea.w, ea.rdata);
            end
        end
    endtask

    task automatic test_single_write();
        bit ok; int c; issue_t ei, oi; ack_t ea, oa;
        clear_queues();
        resp_en = 1'b1; resp_delay = 2;
        step(); c = cyc;
        s0_up_wreq = 1'b1; s0_up_waddr = 14'h0010; s0_up_wdata = 32'h1;
        exp_issue.push_back(mk_issue(c + 2, 1'b1, 14'h0010, 32'h1));
        exp_ack.push_back(mk_ack(c + 5, 0, 1'b1, 0));
        step(); s0_up_wreq = 1'b0;
        wait_for(1, 1, 40, ok);
        checks++;
        if (!ok || obs_issue.size() != 1 || obs_ack.size() != 1) begin
            errors++;
            $display("[TB] FAIL write_count got %0d/%0d want 1/1", obs_issue.size(), obs_ack.size());
        end
        if (obs_issue.size() > 0) begin
            ei = exp_issue.pop_front(); oi = obs_issue.pop_front();
            checks++;
            if (oi.cyc !== ei.cyc || oi.w !== ei.w || oi.addr !== ei.addr || oi.data !== ei.data) begin
                errors++;
                $display("[TB] FAIL write_issue got cyc=%0d w=%0b addr=%h data=%h want cyc=%0d w=%0b addr=%h data=%h", oi.cyc, oi.w, oi.addr, oi.data, ei.cyc, ei.w, ei.addr, ei.data);
            end
        end
        if (obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front();
            checks++;
            if (oa.cyc !== ea.cyc || oa.id !== ea.id || oa.w !== ea.w) begin
                errors++;
                $display("[TB] FAIL write_ack got cyc=%0d id=%0d w=%0b want cyc=%0d id=%0d w=%0b", oa.cyc, oa.id, oa.w, ea.cyc, ea.id, ea.w);
            end
        end
    endtask

    task automatic test_write_before_read();
        bit ok; int c; issue_t ei, oi; ack_t ea, oa;
        clear_queues();
        resp_en = 1'b1; resp_delay = 2;
        step(); c = cyc;
        s1_up_wreq = 1'b1; s1_up_waddr = 14'h0040; s1_up_wdata = 32'hCAFE_0001;
        s1_up_rreq = 1'b1; s1_up_raddr = 14'h0044;
        exp_issue.push_back(mk_issue(c + 2, 1'b1, 14'h0040, 32'hCAFE_0001));
        exp_ack.push_back(mk_ack(c + 5, 1, 1'b1, 0));
        exp_issue.push_back(mk_issue(c + 6, 1'b0, 14'h0044, 0));
        exp_ack.push_back(mk_ack(c + 9, 1, 1'b0, resp_data(14'h0044)));
        step(); s1_up_wreq = 1'b0; s1_up_rreq = 1'b0;
        wait_for(2, 2, 40, ok);
        checks++;
        if (obs_issue.size() != 2 || obs_ack.size() != 2) begin
            errors++;
            $display("[TB] FAIL wbr_count got %0d/%0d want 2/2", obs_issue.size(), obs_ack.size());
        end
        while (exp_issue.size() > 0 && obs_issue.size() > 0) begin
            ei = exp_issue.pop_front(); oi = obs_issue.pop_front();
            checks++;
            if (oi.cyc !== ei.cyc || oi.w !== ei.w || oi.addr !== ei.addr || (ei.w && oi.data !== ei.data)) begin
                errors++;
                $display("[TB] FAIL wbr_issue got cyc=%0d w=%0b addr=%h data=%h want cyc=%0d w=%0b addr=%h data=%h", oi.cyc, oi.w, oi.addr, oi.data, ei.cyc, ei.w, ei.addr, ei.data);
            end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front();
            checks++;
            if (oa.cyc !== ea.cyc || oa.id !== ea.id || oa.w !== ea.w || (!ea.w && oa.rdata !== ea.rdata)) begin
                errors++;
                $display("[TB] FAIL wbr_ack got cyc=%0d id=%0d w=%0b rd=%h want cyc=%0d id=%0d w=%0b rd=%h", oa.cyc, oa.id, oa.w, oa.rdata, ea.cyc, ea.id, ea.w, ea.rdata);
            end
        end
    endtask

    task automatic test_drop();
        bit ok; int c; issue_t ei, oi; ack_t ea, oa;
        clear_queues();
        resp_en = 1'b1; resp_delay = 4;
        step(); c = cyc;
        s0_up_wreq = 1'b1; s0_up_waddr = 14'h0020; s0_up_wdata = 32'h1;
        exp_issue.push_back(mk_issue(c + 2, 1'b1, 14'h0020, 32'h1));
        exp_ack.push_back(mk_ack(c + 7, 0, 1'b1, 0));
        step();
        s0_up_waddr = 14'h0022; s0_up_wdata = 32'h2;
        step(); s0_up_wreq = 1'b0;
        while (cyc < c + 6) step();
        s0_up_wreq = 1'b1; s0_up_waddr = 14'h0024; s0_up_wdata = 32'h3;
        exp_issue.push_back(mk_issue(c + 8, 1'b1, 14'h0024, 32'h3));
        exp_ack.push_back(mk_ack(c + 13, 0, 1'b1, 0));
        step(); s0_up_wreq = 1'b0;
        wait_for(2, 2, 40, ok);
        checks++;
        if (obs_drop_cyc.size() != 1) begin
            errors++;
            $display("[TB] FAIL drop_count got %0d want 1", obs_drop_cyc.size());
        end else begin
            checks++;
            if (obs_drop_cyc[0] !== c + 2 || obs_drop_bits[0] !== 2'b01) begin
                errors++;
                $display("[TB] FAIL drop_pulse got cyc=%0d bits=%b want cyc=%0d bits=01", obs_drop_cyc[0], obs_drop_bits[0], c + 2);
            end
        end
        checks++;
        if (obs_issue.size() != 2 || obs_ack.size() != 2) begin
            errors++;
            $display("[TB] FAIL drop_txn_count got %0d/%0d want 2/2", obs_issue.size(), obs_ack.size());
        end
        while (exp_issue.size() > 0 && obs_issue.size() > 0) begin
            ei = exp_issue.pop_front(); oi = obs_issue.pop_front();
            checks++;
            if (oi.cyc !== ei.cyc || oi.w !== ei.w || oi.addr !== ei.addr || oi.data !== ei.data) begin
                errors++;
                $display("[TB] FAIL drop_issue got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h", oi.cyc, oi.addr, oi.data, ei.cyc, ei.addr, ei.data);
            end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front();
            checks++;
            if (oa.cyc !== ea.cyc || oa.id !== ea.id || oa.w !== ea.w) begin
                errors++;
                $display("[TB] FAIL drop_ack got cyc=%0d id=%0d w=%0b want cyc=%0d id=%0d w=%0b", oa.cyc, oa.id, oa.w, ea.cyc, ea.id, ea.w);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok; int c; issue_t ei, oi; ack_t ea, oa;
        clear_queues();
        resp_en = 1'b0;
        step(); c = cyc;
        s0_up_rreq = 1'b1; s0_up_raddr = 14'h0050;
        exp_issue.push_back(mk_issue(c + 2, 1'b0, 14'h0050, 0));
        exp_ack.push_back(mk_ack(c + 2 + TO_CYC, 0, 1'b0, 32'hDEAD_DEAD));
        step(); s0_up_rreq = 1'b0;
        while (cyc < c + 1 + TO_CYC) step();
        checks++;
        if (up_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_early got %b want 0", up_timeout);
        end
        step();
        checks++;
        if (up_timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_set got %b want 1", up_timeout);
        end
        step(); up_timeout_clr = 1'b1;
        step(); up_timeout_clr = 1'b0;
        checks++;
        if (up_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_clr got %b want 0", up_timeout);
        end
        step(); c = cyc;
        s1_up_rreq = 1'b1; s1_up_raddr = 14'h0052;
        exp_issue.push_back(mk_issue(c + 2, 1'b0, 14'h0052, 0));
        exp_ack.push_back(mk_ack(c + 2 + TO_CYC, 1, 1'b0, 32'hDEAD_DEAD));
        step(); s1_up_rreq = 1'b0;
        while (cyc < c + 1 + TO_CYC) step();
        up_timeout_clr = 1'b1;
        step(); up_timeout_clr = 1'b0;
        checks++;
        if (up_timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_set_vs_clr got %b want 1", up_timeout);
        end
        wait_for(2, 2, 40, ok);
        checks++;
        if (obs_issue.size() != 2 || obs_ack.size() != 2) begin
            errors++;
            $display("[TB] FAIL timeout_count got %0d/%0d want 2/2", obs_issue.size(), obs_ack.size());
        end
        while (exp_issue.size() > 0 && obs_issue.size() > 0) begin
            ei = exp_issue.pop_front(); oi = obs_issue.pop_front();
            checks++;
            if (oi.cyc !== ei.cyc || oi.w !== ei.w || oi.addr !== ei.addr) begin
                errors++;
                $display("[TB] FAIL timeout_issue got cyc=%0d addr=%h want cyc=%0d addr=%h", oi.cyc, oi.addr, ei.cyc, ei.addr);
            end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front();
            checks++;
            if (oa.cyc !== ea.cyc || oa.id !== ea.id || oa.w !== ea.w || oa.rdata !== ea.rdata) begin
                errors++;
                $display("[TB] FAIL timeout_ack got cyc=%0d id=%0d rd=%h want cyc=%0d id=%0d rd=%h", oa.cyc, oa.id, oa.rdata, ea.cyc, ea.id, ea.rdata);
            end
        end
        step(); up_timeout_clr = 1'b1;
        step(); up_timeout_clr = 1'b0;
        resp_en = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int c; issue_t ei, oi; ack_t ea, oa;
        clear_queues();
        resp_en = 1'b0;
        step(); c = cyc;
        s1_up_wreq = 1'b1; s1_up_waddr = 14'h0060; s1_up_wdata = 32'h66;
        step(); s1_up_wreq = 1'b0;
        while (cyc < c + 5) step();
        checks++;
        if (obs_issue.size() != 1) begin
            errors++;
            $display("[TB] FAIL rst_pre_issue got %0d want 1", obs_issue.size());
        end
        up_rstn = 1'b0;
        #1;
        checks++;
        if ({m_up_wreq, m_up_rreq, m_up_waddr, m_up_wdata, s0_up_wack, s1_up_wack, up_drop, up_timeout} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_async got %h want 0", {m_up_wreq, m_up_rreq, m_up_waddr, m_up_wdata, s0_up_wack, s1_up_wack, up_drop, up_timeout});
        end
        step(); step();
        up_rstn = 1'b1;
        clear_queues();
        repeat (2 * TO_CYC) step();
        checks++;
        if (obs_issue.size() != 0 || obs_ack.size() != 0) begin
            errors++;
            $display("[TB] FAIL rst_no_ack got %0d/%0d want 0/0", obs_issue.size(), obs_ack.size());
        end
        resp_en = 1'b1; resp_delay = 2;
        step(); c = cyc;
        s0_up_wreq = 1'b1; s0_up_waddr = 14'h0070; s0_up_wdata = 32'h7;
        exp_issue.push_back(mk_issue(c + 2, 1'b1, 14'h0070, 32'h7));
        exp_ack.push_back(mk_ack(c + 5, 0, 1'b1, 0));
        step(); s0_up_wreq = 1'b0;
        wait_for(1, 1, 40, ok);
        checks++;
        if (obs_issue.size() != 1 || obs_ack.size() != 1) begin
            errors++;
            $display("[TB] FAIL rst_after_count got %0d/%0d want 1/1", obs_issue.size(), obs_ack.size());
        end
        while (exp_issue.size() > 0 && obs_issue.size() > 0) begin
            ei = exp_issue.pop_front(); oi = obs_issue.pop_front();
            checks++;
            if (oi.cyc !== ei.cyc || oi.w !== ei.w || oi.addr !== ei.addr || oi.data !== ei.data) begin
                errors++;
                $display("[TB] FAIL rst_after_issue got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h", oi.cyc, oi.addr, oi.data, ei.cyc, ei.addr, ei.data);
            end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front();
            checks++;
            if (oa.cyc !== ea.cyc || oa.id !== ea.id || oa.w !== ea.w) begin
                errors++;
                $display("[TB] FAIL rst_after_ack got cyc=%0d id=%0d w=%0b want cyc=%0d id=%0d w=%0b", oa.cyc, oa.id, oa.w, ea.cyc, ea.id, ea.w);
            end
        end
    endtask

    task automatic test_rdata_idle();
        checks++;
        if (rdata_leak !== 0) begin
            errors++;
            $display("[TB] FAIL rdata_idle got %0d nonzero cycles want 0", rdata_leak);
        end
    endtask

    initial begin
        up_rstn = 1'b0;
        s0_up_wreq = 1'b0; s0_up_rreq = 1'b0; s1_up_wreq = 1'b0; s1_up_rreq = 1'b0;
        s0_up_waddr = '0; s0_up_raddr = '0; s1_up_waddr = '0; s1_up_raddr = '0;
        s0_up_wdata = '0; s1_up_wdata = '0;
        up_timeout_clr = 1'b0;
        repeat (3) step();
        test_reset();
        up_rstn = 1'b1;
        repeat (2) step();
        test_fairness();
        test_single_write();
        test_write_before_read();
        test_drop();
        test_timeout();
        test_reset_mid_wait();
        test_rdata_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
